song_sequencer: RTL



---
 rtl/song_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song ROM and hands note/duration pairs to the note player.
// Optional SONG_LOOP_EN: end of song pulses song_done and restarts the song instead of stopping.
module song_sequencer #(
  parameter int unsigned SONG_BITS  = 2,
  parameter int unsigned INDEX_BITS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [SONG_BITS-1:0]           song,
  input  logic                           note_done,
  output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
  input  logic [11:0]                    rom_data,
  output logic [5:0]                     note_to_load,
  output logic [5:0]                     duration_to_load,
  output logic                           load_new_note,
  output logic                           song_done,
  output logic [INDEX_BITS-1:0]          note_index
);

  localparam int unsigned NOTE_BITS = 6;
  localparam int unsigned DUR_BITS  = 6;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    PLAYING,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   index_q, index_d;
  logic [SONG_BITS-1:0]    song_q, song_d;
  logic [NOTE_BITS-1:0]    note_d;
  logic [DUR_BITS-1:0]     dur_d;
  logic [INDEX_BITS-1:0]   nidx_d;
  logic                    done_d;
  logic                    end_song;

  logic [NOTE_BITS-1:0]    rom_note;
  logic [DUR_BITS-1:0]     rom_dur;

  assign rom_note      = rom_data[11:6];
  assign rom_dur       = rom_data[5:0];
  assign rom_addr      = {song_q, index_q};
  assign load_new_note = (state_q == LOAD);

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      index_q          <= '0;
      song_q           <= song;
      note_to_load     <= '0;
      duration_to_load <= '0;
      song_done        <= 1'b0;
      note_index       <= '0;
    end else begin
      state_q          <= state_d;
      index_q          <= index_d;
      song_q           <= song_d;
      note_to_load     <= note_d;
      duration_to_load <= dur_d;
      song_done        <= done_d;
      note_index       <= nidx_d;
    end
  end

  // Next-state logic; a song change overrides any pending transition
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    song_d   = song_q;
    note_d   = note_to_load;
    dur_d    = duration_to_load;
    nidx_d   = note_index;
`ifdef SONG_LOOP_EN
    done_d   = 1'b0;
`else
    done_d   = song_done;
`endif
    end_song = 1'b0;

    if (song != song_q) begin
      song_d  = song;
      index_d = '0;
      done_d  = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) state_d = FETCH;
        end
        FETCH: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (rom_dur == DUR_BITS'(0)) begin
            end_song = 1'b1;
          end else begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            nidx_d  = index_q;
            state_d = LOAD;
          end
        end
        LOAD: begin
          state_d = PLAYING;
        end
        PLAYING: begin
          if (note_done) begin
            if (index_q != '1) begin
              index_d = index_q + INDEX_BITS'(1);
              state_d = FETCH;
            end else begin
              end_song = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // Song end: stop in DONE, or restart from the first entry when looping
      if (end_song) begin
        done_d = 1'b1;
`ifdef SONG_LOOP_EN
        index_d = '0;
        state_d = FETCH;
`else
        state_d = DONE;
`endif
      end
    end
  end

endmodule
